// File: rtl/stopwatch_timer.sv
// mm:ss BCD stopwatch / countdown timer with internal 1 Hz tick and adjust-rate enable.
// Optional lap/hold display freeze is compiled in when STOPWATCH_LAP_EN is defined.
module stopwatch_timer #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int ADJ_HZ  = 2,
  parameter int MAX_MIN = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pause,
  input  logic       clr,
  input  logic       adj,
  input  logic       sel,
  input  logic       dir,
  input  logic       lap,
  output logic [3:0] m10,
  output logic [3:0] m1,
  output logic [2:0] s10,
  output logic [3:0] s1,
  output logic       running,
  output logic       done,
  output logic       wrap,
  output logic       hold
);

  localparam int ADJ_PER = CLK_HZ / ADJ_HZ;
  localparam int DIV_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int ADJ_W   = (ADJ_PER > 1) ? $clog2(ADJ_PER) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HZ - 1);
  localparam logic [ADJ_W-1:0] ADJ_LAST = ADJ_W'(ADJ_PER - 1);
  localparam logic [3:0] MAX_M10 = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_M1  = 4'(MAX_MIN % 10);

  typedef enum logic [1:0] {S_PAUSED, S_RUN, S_ADJUST, S_DONE} state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic [ADJ_W-1:0] r_adj_cnt;
  logic [3:0]       r_m10, r_m1, r_s1;
  logic [2:0]       r_s10;
  logic             r_running, r_done, r_wrap;

  logic       w_tick, w_adj_en, w_min_max, w_is_zero, w_dn_end;
  logic       w_c0, w_c1, w_b0, w_b1, w_up_wrap;
  logic [3:0] w_inc_m10, w_inc_m1, w_up_s1, w_dn_m10, w_dn_m1, w_dn_s1;
  logic [2:0] w_up_s10, w_dn_s10;

  always_comb begin
    w_tick    = (r_state == S_RUN) && (r_div == DIV_LAST);
    w_adj_en  = (r_state == S_ADJUST) && (r_adj_cnt == ADJ_LAST);
    w_min_max = (r_m10 == MAX_M10) && (r_m1 == MAX_M1);
    w_is_zero = (r_m10 == 4'd0) && (r_m1 == 4'd0) && (r_s10 == 3'd0) && (r_s1 == 4'd0);
    // A down tick ends the count when it starts at 00:01 (lands on zero) or at 00:00.
    w_dn_end  = (r_m10 == 4'd0) && (r_m1 == 4'd0) && (r_s10 == 3'd0) && (r_s1 <= 4'd1);

    // Minutes +1 on the BCD pair, wrapping past MAX_MIN; shared by up-count and adjust.
    w_inc_m10 = r_m10;
    w_inc_m1  = r_m1 + 4'd1;
    if (w_min_max) begin
      w_inc_m10 = 4'd0;
      w_inc_m1  = 4'd0;
    end else if (r_m1 == 4'd9) begin
      w_inc_m10 = r_m10 + 4'd1;
      w_inc_m1  = 4'd0;
    end

    // Seconds +1 wraps 59 -> 00, so the same values serve seconds adjust.
    w_c0      = (r_s1 == 4'd9);
    w_c1      = w_c0 && (r_s10 == 3'd5);
    w_up_s1   = w_c0 ? 4'd0 : r_s1 + 4'd1;
    w_up_s10  = r_s10;
    if (w_c0) w_up_s10 = (r_s10 == 3'd5) ? 3'd0 : r_s10 + 3'd1;
    w_up_wrap = w_c1 && w_min_max;

    w_b0     = (r_s1 == 4'd0);
    w_b1     = w_b0 && (r_s10 == 3'd0);
    w_dn_s1  = w_b0 ? 4'd9 : r_s1 - 4'd1;
    w_dn_s10 = r_s10;
    if (w_b0) w_dn_s10 = (r_s10 == 3'd0) ? 3'd5 : r_s10 - 3'd1;
    w_dn_m10 = r_m10;
    w_dn_m1  = r_m1;
    if (w_b1) begin
      if (r_m1 == 4'd0) begin
        w_dn_m1  = 4'd9;
        w_dn_m10 = r_m10 - 4'd1;
      end else begin
        w_dn_m1  = r_m1 - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_PAUSED;
      r_div     <= '0;
      r_adj_cnt <= '0;
      r_m10     <= 4'd0;
      r_m1      <= 4'd0;
      r_s10     <= 3'd0;
      r_s1      <= 4'd0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (clr) begin
        r_m10     <= 4'd0;
        r_m1      <= 4'd0;
        r_s10     <= 3'd0;
        r_s1      <= 4'd0;
        r_div     <= '0;
        r_adj_cnt <= '0;
        r_running <= 1'b0;
        r_done    <= 1'b0;
        r_state   <= adj ? S_ADJUST : S_PAUSED;
      end else begin
        // The tick advances the count even when this edge also leaves RUN.
        if (w_tick) begin
          r_div <= '0;
          if (!dir) begin
            r_s1   <= w_up_s1;
            r_s10  <= w_up_s10;
            if (w_c1) begin
              r_m10 <= w_inc_m10;
              r_m1  <= w_inc_m1;
            end
            r_wrap <= w_up_wrap;
          end else if (!w_is_zero) begin
            r_s1  <= w_dn_s1;
            r_s10 <= w_dn_s10;
            r_m1  <= w_dn_m1;
            r_m10 <= w_dn_m10;
          end
        end else if (r_state == S_RUN) begin
          r_div <= r_div + 1'b1;
        end

        case (r_state)
          S_PAUSED: begin
            if (adj) begin
              r_state   <= S_ADJUST;
              r_adj_cnt <= '0;
            end else if (pause) begin
              r_state   <= S_RUN;
              r_running <= 1'b1;
            end
          end
          S_RUN: begin
            if (adj) begin
              r_state   <= S_ADJUST;
              r_adj_cnt <= '0;
              r_running <= 1'b0;
            end else if (pause) begin
              r_state   <= S_PAUSED;
              r_running <= 1'b0;
            end else if (w_tick && dir && w_dn_end) begin
              r_state   <= S_DONE;
              r_running <= 1'b0;
              r_done    <= 1'b1;
            end
          end
          S_ADJUST: begin
            if (!adj) begin
              r_state <= S_PAUSED;
            end else if (w_adj_en) begin
              r_adj_cnt <= '0;
              if (sel) begin
                r_s1  <= w_up_s1;
                r_s10 <= w_up_s10;
              end else begin
                r_m10 <= w_inc_m10;
                r_m1  <= w_inc_m1;
              end
            end else begin
              r_adj_cnt <= r_adj_cnt + 1'b1;
            end
          end
          S_DONE: begin
            if (adj) begin
              r_state   <= S_ADJUST;
              r_adj_cnt <= '0;
              r_done    <= 1'b0;
            end else if (pause) begin
              r_state <= S_PAUSED;
              r_done  <= 1'b0;
            end
          end
          default: r_state <= S_PAUSED;
        endcase
      end
    end
  end

  assign running = r_running;
  assign done    = r_done;
  assign wrap    = r_wrap;

`ifdef STOPWATCH_LAP_EN
  logic [3:0] r_snap_m10, r_snap_m1, r_snap_s1;
  logic [2:0] r_snap_s10;
  logic       r_hold;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold     <= 1'b0;
      r_snap_m10 <= 4'd0;
      r_snap_m1  <= 4'd0;
      r_snap_s10 <= 3'd0;
      r_snap_s1  <= 4'd0;
    end else if (clr) begin
      r_hold <= 1'b0;
    end else if (lap) begin
      if (!r_hold) begin
        r_snap_m10 <= r_m10;
        r_snap_m1  <= r_m1;
        r_snap_s10 <= r_s10;
        r_snap_s1  <= r_s1;
      end
      r_hold <= !r_hold;
    end
  end

  assign m10  = r_hold ? r_snap_m10 : r_m10;
  assign m1   = r_hold ? r_snap_m1  : r_m1;
  assign s10  = r_hold ? r_snap_s10 : r_s10;
  assign s1   = r_hold ? r_snap_s1  : r_s1;
  assign hold = r_hold;
`else
  logic w_lap_unused;
  assign w_lap_unused = lap;
  assign m10  = r_m10;
  assign m1   = r_m1;
  assign s10  = r_s10;
  assign s1   = r_s1;
  assign hold = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_timer.sv
// Scoreboard bench for stopwatch_timer (CLK_HZ=4, ADJ_HZ=2, MAX_MIN=1): stimulus queues
// expected outputs tagged with a cycle number; a negedge monitor pops and compares them.
module tb_stopwatch_timer;
  logic       clk = 1'b0;
  logic       rst, pause, clr, adj, sel, dir, lap;
  logic [3:0] m10, m1, s1;
  logic [2:0] s10;
  logic       running, done, wrap, hold;

  int cyc = 0;
  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    string       name;
    int          cyc;
    logic [18:0] val;
  } exp_t;
  exp_t sb_q[$];

  stopwatch_timer #(.CLK_HZ(4), .ADJ_HZ(2), .MAX_MIN(1)) dut (
    .clk(clk), .rst(rst), .pause(pause), .clr(clr), .adj(adj), .sel(sel),
    .dir(dir), .lap(lap), .m10(m10), .m1(m1), .s10(s10), .s1(s1),
    .running(running), .done(done), .wrap(wrap), .hold(hold)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [18:0] pack(int mm, int ss, int run, int dn, int wr, int hd);
    logic [3:0] a, b, d;
    logic [2:0] c;
    a = 4'(mm / 10);
    b = 4'(mm % 10);
    c = 3'(ss / 10);
    d = 4'(ss % 10);
    return {a, b, c, d, 1'(run), 1'(dn), 1'(wr), 1'(hd)};
  endfunction

  function automatic string fmt(logic [18:0] v);
    return $sformatf("%0d%0d:%0d%0d run=%0b done=%0b wrap=%0b hold=%0b",
                     v[18:15], v[14:11], v[10:8], v[7:4], v[3], v[2], v[1], v[0]);
  endfunction

  // Expected display mm:ss and flags k clock edges from now.
  task automatic expect_at(string name, int k, int mm, int ss, int run, int dn, int wr, int hd);
    exp_t e;
    e.name = name;
    e.cyc  = cyc + k;
    e.val  = pack(mm, ss, run, dn, wr, hd);
    sb_q.push_back(e);
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe_pause();
    pause = 1'b1;
    step(1);
    pause = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    logic [18:0] act;
    exp_t        e;
    act = {m10, m1, s10, s1, running, done, wrap, hold};
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      tests_run++;
      if (e.cyc < cyc) begin
        tests_failed++;
        $display("FAIL %s: check slot missed (due cycle %0d, now %0d)", e.name, e.cyc, cyc);
      end else if (act !== e.val) begin
        tests_failed++;
        $display("FAIL %s: got %s, required %s", e.name, fmt(act), fmt(e.val));
      end else begin
        $display("[TB] ok %s: %s", e.name, fmt(act));
      end
    end
  end

  initial begin
    rst = 1'b0; pause = 1'b0; clr = 1'b0; adj = 1'b0; sel = 1'b0; dir = 1'b0; lap = 1'b0;
    step(1);
    expect_at("reset_state", 1, 0, 0, 0, 0, 0, 0);
    step(1);
    rst = 1'b1;

    // Reset and first tick
    expect_at("run_entry", 1, 0, 0, 1, 0, 0, 0);
    strobe_pause();
    expect_at("pre_tick", 3, 0, 0, 1, 0, 0, 0);
    expect_at("first_tick", 4, 0, 1, 1, 0, 0, 0);
    expect_at("before_4s", 15, 0, 3, 1, 0, 0, 0);
    expect_at("count_4s", 16, 0, 4, 1, 0, 0, 0);
    step(16);

    // clr + pause mid-divider: clear wins, divider restarts from 0
    step(2);
    clr = 1'b1; pause = 1'b1;
    expect_at("clr_pause", 1, 0, 0, 0, 0, 0, 0);
    step(1);
    clr = 1'b0; pause = 1'b0;
    expect_at("clr_holds", 3, 0, 0, 0, 0, 0, 0);
    step(3);
    expect_at("restart", 1, 0, 0, 1, 0, 0, 0);
    strobe_pause();
    expect_at("div_cleared", 3, 0, 0, 1, 0, 0, 0);
    step(3);
    pause = 1'b1;
    expect_at("pause_on_tick", 1, 0, 1, 0, 0, 0, 0);
    step(1);
    pause = 1'b0;
    expect_at("paused_hold", 8, 0, 1, 0, 0, 0, 0);
    step(8);

    // Adjust mode
    clr = 1'b1;
    expect_at("clr_paused", 1, 0, 0, 0, 0, 0, 0);
    step(1);
    clr = 1'b0;
    adj = 1'b1; sel = 1'b1;
    expect_at("adj_sec_3", 8, 0, 3, 0, 0, 0, 0);
    expect_at("adj_sec_4", 9, 0, 4, 0, 0, 0, 0);
    step(9);
    sel = 1'b0;
    expect_at("adj_min_1", 2, 1, 4, 0, 0, 0, 0);
    expect_at("adj_min_wrap", 4, 0, 4, 0, 0, 0, 0);
    expect_at("adj_min_1b", 6, 1, 4, 0, 0, 0, 0);
    step(6);
    sel = 1'b1;
    expect_at("adj_to_0159", 110, 1, 59, 0, 0, 0, 0);
    expect_at("adj_sec_wrap", 112, 1, 0, 0, 0, 0, 0);
    expect_at("adj_back_0159", 230, 1, 59, 0, 0, 0, 0);
    step(230);
    adj = 1'b0; sel = 1'b0;
    expect_at("adj_exit", 1, 1, 59, 0, 0, 0, 0);
    step(1);

    // Up-count rollover from MAX_MIN:59
    dir = 1'b0;
    expect_at("roll_run", 1, 1, 59, 1, 0, 0, 0);
    strobe_pause();
    expect_at("roll_pre", 3, 1, 59, 1, 0, 0, 0);
    expect_at("roll_wrap", 4, 0, 0, 1, 0, 1, 0);
    expect_at("wrap_1cycle", 5, 0, 0, 1, 0, 0, 0);
    step(5);

    // Divider holds its partial count through ADJUST and PAUSED
    adj = 1'b1; sel = 1'b1;
    expect_at("adj_from_run", 3, 0, 1, 0, 0, 0, 0);
    step(3);
    adj = 1'b0;
    expect_at("adj_exit2", 1, 0, 1, 0, 0, 0, 0);
    step(1);
    expect_at("rerun", 1, 0, 1, 1, 0, 0, 0);
    strobe_pause();
    expect_at("div_held", 1, 0, 1, 1, 0, 0, 0);
    expect_at("div_held_tick", 2, 0, 2, 1, 0, 0, 0);
    step(2);
    expect_at("stop", 1, 0, 2, 0, 0, 0, 0);
    strobe_pause();

    // Countdown to DONE
    clr = 1'b1;
    expect_at("clr_cd", 1, 0, 0, 0, 0, 0, 0);
    step(1);
    clr = 1'b0;
    adj = 1'b1; sel = 1'b1;
    expect_at("adj_to_0002", 5, 0, 2, 0, 0, 0, 0);
    step(5);
    adj = 1'b0; sel = 1'b0;
    expect_at("cd_paused", 1, 0, 2, 0, 0, 0, 0);
    step(1);
    dir = 1'b1;
    expect_at("cd_run", 1, 0, 2, 1, 0, 0, 0);
    strobe_pause();
    expect_at("cd_0001", 4, 0, 1, 1, 0, 0, 0);
    expect_at("cd_0001_hold", 7, 0, 1, 1, 0, 0, 0);
    expect_at("cd_done", 8, 0, 0, 0, 1, 0, 0);
    expect_at("done_holds", 12, 0, 0, 0, 1, 0, 0);
    step(12);
    expect_at("done_pause", 1, 0, 0, 0, 0, 0, 0);
    strobe_pause();
    expect_at("zero_run", 1, 0, 0, 1, 0, 0, 0);
    strobe_pause();
    expect_at("zero_pre", 3, 0, 0, 1, 0, 0, 0);
    expect_at("zero_done", 4, 0, 0, 0, 1, 0, 0);
    step(4);
    clr = 1'b1; dir = 1'b0;
    expect_at("done_clr", 1, 0, 0, 0, 0, 0, 0);
    step(1);
    clr = 1'b0;

`ifdef STOPWATCH_LAP_EN
    expect_at("lap_run", 1, 0, 0, 1, 0, 0, 0);
    strobe_pause();
    expect_at("lap_live_0002", 8, 0, 2, 1, 0, 0, 0);
    step(8);
    lap = 1'b1;
    expect_at("lap_freeze", 1, 0, 2, 1, 0, 0, 1);
    step(1);
    lap = 1'b0;
    expect_at("lap_frozen", 4, 0, 2, 1, 0, 0, 1);
    expect_at("lap_frozen2", 11, 0, 2, 1, 0, 0, 1);
    step(11);
    lap = 1'b1;
    expect_at("lap_release", 1, 0, 5, 1, 0, 0, 0);
    step(1);
    lap = 1'b0;
    expect_at("lap_live_0006", 4, 0, 6, 1, 0, 0, 0);
    step(4);
    lap = 1'b1;
    expect_at("lap_again", 1, 0, 6, 1, 0, 0, 1);
    step(1);
    lap = 1'b0;
`else
    expect_at("nolap_run", 1, 0, 0, 1, 0, 0, 0);
    strobe_pause();
    lap = 1'b1;
    expect_at("lap_ignored", 1, 0, 0, 1, 0, 0, 0);
    step(1);
    lap = 1'b0;
    expect_at("nolap_live", 7, 0, 2, 1, 0, 0, 0);
    step(7);
    lap = 1'b1;
    expect_at("lap_ignored2", 1, 0, 2, 1, 0, 0, 0);
    step(1);
    lap = 1'b0;
`endif

    // Reset pulse entirely between clock edges must still take effect
    expect_at("async_reset", 1, 0, 0, 0, 0, 0, 0);
    #1 rst = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    expect_at("reset_paused", 4, 0, 0, 0, 0, 0, 0);
    step(4);

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) step(1);
    while (sb_q.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s: never compared (due cycle %0d)", sb_q[0].name, sb_q[0].cyc);
      void'(sb_q.pop_front());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
